// File: rtl/keypad_emulator_if.sv
// Command handshake between a press source and the keypad emulator.
// Groups the key-press strobe/code/bounce and the ready/busy/done/err status.
// master: press source (drives command, reads status); slave: emulator.
interface keypad_emulator_if;
    logic       key_valid;   // one-cycle command strobe
    logic [3:0] key_code;    // row*3 + col, 0..11
    logic [3:0] key_bounce;  // bounce pulses for press and release
    logic       ready;       // emulator idle, command accepted
    logic       busy;        // emulator running a press
    logic       done;        // one-cycle pulse on return to idle
    logic       err;         // one-cycle pulse on out-of-range code

    modport master (
        output key_valid, key_code, key_bounce,
        input  ready, busy, done, err
    );

    modport slave (
        input  key_valid, key_code, key_bounce,
        output ready, busy, done, err
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x3 matrix keypad responder: closes one contact with press/release bounce.
// Latency: contact closes the cycle after an accepted strobe; rows->cols combinational.
// Backpressure: commands are accepted only while ready; strobes while busy are dropped.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   cmd                : command handshake (key_valid/key_code/key_bounce in,
//                        ready/busy/done/err out)
//   A..D               : row drives from the scanner (row 0..3), active-high
//   E..G               : column returns (col 0..2), active-high
module keypad_emulator #(
    parameter int BOUNCE_PERIOD = 4,
    parameter int HOLD_CYCLES   = 64,
    parameter int CNT_W         = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    keypad_emulator_if.slave   cmd,
    input  logic               A,
    input  logic               B,
    input  logic               C,
    input  logic               D,
    output logic               E,
    output logic               F,
    output logic               G
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] BP_LOAD   = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state;
    logic             contact;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [3:0]       n_q;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       seg;
    logic             done_q;
    logic             err_q;

    logic [3:0]       rc_nxt;    // {row, col} decoded from key_code
    logic             code_ok;
    logic [4:0]       seg_last;
    logic [3:0]       rows;

    // Key index to matrix position; anything above 11 is out of range.
    always_comb begin
        rc_nxt  = 4'h0;
        code_ok = 1'b1;
        case (cmd.key_code)
            4'd0:    rc_nxt = {2'd0, 2'd0};
            4'd1:    rc_nxt = {2'd0, 2'd1};
            4'd2:    rc_nxt = {2'd0, 2'd2};
            4'd3:    rc_nxt = {2'd1, 2'd0};
            4'd4:    rc_nxt = {2'd1, 2'd1};
            4'd5:    rc_nxt = {2'd1, 2'd2};
            4'd6:    rc_nxt = {2'd2, 2'd0};
            4'd7:    rc_nxt = {2'd2, 2'd1};
            4'd8:    rc_nxt = {2'd2, 2'd2};
            4'd9:    rc_nxt = {2'd3, 2'd0};
            4'd10:   rc_nxt = {2'd3, 2'd1};
            4'd11:   rc_nxt = {2'd3, 2'd2};
            default: code_ok = 1'b0;
        endcase
    end

    // Last segment index of a bounce phase: 2n-1 (only used when n > 0).
    assign seg_last = {n_q, 1'b0} - 5'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            contact <= 1'b0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            n_q     <= 4'd0;
            cnt     <= '0;
            seg     <= 5'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.key_valid) begin
                        if (code_ok) begin
                            row_q   <= rc_nxt[3:2];
                            col_q   <= rc_nxt[1:0];
                            n_q     <= cmd.key_bounce;
                            contact <= 1'b1;
                            seg     <= 5'd0;
                            if (cmd.key_bounce != 4'd0) begin
                                state <= S_PRESS;
                                cnt   <= BP_LOAD;
                            end else begin
                                state <= S_HOLD;
                                cnt   <= HOLD_LOAD;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_PRESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (seg == seg_last) begin
                        state   <= S_HOLD;
                        contact <= 1'b1;
                        cnt     <= HOLD_LOAD;
                    end else begin
                        // Next segment even -> closed; current odd means next even.
                        seg     <= seg + 5'd1;
                        contact <= seg[0];
                        cnt     <= BP_LOAD;
                    end
                end
                S_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (n_q != 4'd0) begin
                        state   <= S_RELEASE;
                        seg     <= 5'd0;
                        contact <= 1'b0;
                        cnt     <= BP_LOAD;
                    end else begin
                        state   <= S_IDLE;
                        contact <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (seg == seg_last) begin
                        state   <= S_IDLE;
                        contact <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // Release phase is inverted: odd segments closed.
                        seg     <= seg + 5'd1;
                        contact <= ~seg[0];
                        cnt     <= BP_LOAD;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.ready = (state == S_IDLE);
    assign cmd.busy  = (state != S_IDLE);
    assign cmd.done  = done_q;
    assign cmd.err   = err_q;

    // Only the latched row can reach the latched column.
    assign rows = {D, C, B, A};
    assign E = contact & rows[row_q] & (col_q == 2'd0);
    assign F = contact & rows[row_q] & (col_q == 2'd1);
    assign G = contact & rows[row_q] & (col_q == 2'd2);

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed presses compared every cycle against a
// time-offset model of the contact waveform, plus hand-computed literal checks.
module tb_keypad_emulator;
    localparam int BP   = 4;
    localparam int HOLD = 64;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic A = 0, B = 0, C = 0, D = 0;
    logic E, F, G;

    keypad_emulator_if kif();

    keypad_emulator #(.BOUNCE_PERIOD(BP), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd       (kif),
        .A(A), .B(B), .C(C), .D(D),
        .E(E), .F(F), .G(G)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- model: contact as a function of time since press ------
    int cyc      = 0;   // number of clock edges seen
    bit m_act    = 0;
    int m_start  = 0;   // edge at which the command was taken
    int m_row    = 0;
    int m_col    = 0;
    int m_n      = 0;
    int m_len    = 0;   // total contact activity in clocks
    int m_err_at = -1;

    function automatic bit contact_at(input int p, input int n);
        int pb;
        pb = 2 * n * BP;
        if (p < 0)             return 1'b0;
        if (p < pb)            return ((p / BP) % 2) == 0;
        if (p < pb + HOLD)     return 1'b1;
        if (p < 2 * pb + HOLD) return (((p - pb - HOLD) / BP) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input int c);
        return m_act && (c >= m_start) && ((c - m_start) < m_len);
    endfunction

    always @(posedge sys_clk) begin
        int old;
        old = cyc;
        cyc = cyc + 1;
        if (sys_rst_n && kif.key_valid && !m_busy(old)) begin
            if (kif.key_code <= 4'd11) begin
                m_act   = 1;
                m_start = cyc;
                m_row   = int'(kif.key_code) / 3;
                m_col   = int'(kif.key_code) % 3;
                m_n     = int'(kif.key_bounce);
                m_len   = 4 * m_n * BP + HOLD;
            end else begin
                m_err_at = cyc;
            end
        end
    end

    always @(negedge sys_rst_n) begin
        m_act    = 0;
        m_err_at = -1;
    end

    // ---------------- per-cycle compare -------------------------------------
    always @(negedge sys_clk) begin
        int p;
        bit c, eb, ed, er;
        bit [3:0] rows;
        bit [2:0] ecol;
        rows = {D, C, B, A};
        ecol = 3'b000;
        eb = 0; ed = 0; er = 0;
        if (sys_rst_n) begin
            p  = cyc - m_start;
            c  = m_act && contact_at(p, m_n);
            eb = m_busy(cyc);
            ed = m_act && (p == m_len);
            er = (cyc == m_err_at);
            if (c && rows[m_row]) ecol[m_col] = 1'b1;
        end
        chk("col_E", E, ecol[0]);
        chk("col_F", F, ecol[1]);
        chk("col_G", G, ecol[2]);
        chk("ready", kif.ready, !eb);
        chk("busy",  kif.busy, eb);
        chk("done",  kif.done, ed);
        chk("err",   kif.err, er);
    end

    // ---------------- stimulus helpers --------------------------------------
    bit eh [1:200];
    bit fh [1:200];
    bit gh [1:200];
    bit dh [1:200];
    bit rh [1:200];

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe(input int code, input int bounce);
        kif.key_valid  = 1'b1;
        kif.key_code   = 4'(code);
        kif.key_bounce = 4'(bounce);
        step(1);
        kif.key_valid  = 1'b0;
    endtask

    // Record outputs for cycles strobe+1 .. strobe+n; optionally inject two
    // strobes (valid code 4, then invalid code 13) starting at cycle inj.
    task automatic watch(input int n, input int inj);
        for (int k = 1; k <= n; k++) begin
            eh[k] = E; fh[k] = F; gh[k] = G;
            dh[k] = kif.done; rh[k] = kif.err;
            kif.key_valid = 1'b0;
            if (inj > 0 && k == inj)     begin kif.key_valid = 1'b1; kif.key_code = 4'd4;  kif.key_bounce = 4'd0; end
            if (inj > 0 && k == inj + 1) begin kif.key_valid = 1'b1; kif.key_code = 4'd13; kif.key_bounce = 4'd0; end
            step(1);
        end
        kif.key_valid = 1'b0;
    endtask

    function automatic int count(input int which, input int lo, input int hi);
        int s;
        s = 0;
        for (int k = lo; k <= hi; k++) begin
            case (which)
                0: s += int'(eh[k]);
                1: s += int'(fh[k]);
                2: s += int'(gh[k]);
                3: s += int'(dh[k]);
                default: s += int'(rh[k]);
            endcase
        end
        return s;
    endfunction

    function automatic int first_done(input int n);
        for (int k = 1; k <= n; k++) if (dh[k]) return k;
        return -1;
    endfunction

    initial begin
        logic [15:0] pat, want;
        int w;
        kif.key_valid = 0; kif.key_code = 0; kif.key_bounce = 0;

        // Reset state
        #12;
        chk("rst_ready", kif.ready, 1'b1);
        chk("rst_busy",  kif.busy, 1'b0);
        chk("rst_cols",  E | F | G, 1'b0);
        #10 sys_rst_n = 1'b1;
        step(1);

        // Idle, rows walking one
        for (int i = 0; i < 8; i++) begin
            {D, C, B, A} = 4'b0001 << (i % 4);
            step(1);
        end
        {D, C, B, A} = 4'b0000;

        // key 5 (row B, col G), clean contact
        B = 1;
        strobe(5, 0);
        watch(70, 0);
        chk_int("k5_g_high", count(2, 1, 70), 64);
        chk_int("k5_g_last", int'(gh[64]) + 2 * int'(gh[65]), 1);
        chk_int("k5_ef_zero", count(0, 1, 70) + count(1, 1, 70), 0);
        chk_int("k5_done_at", first_done(70), 65);
        B = 0;

        // key 0 (row A, col E), two bounce pulses
        A = 1;
        strobe(0, 2);
        watch(100, 0);
        for (int k = 1; k <= 16; k++) pat[k-1] = eh[k];
        want = 16'h0F0F;
        chk_int("k0_press_pat", int'(pat), int'(want));
        chk_int("k0_hold", count(0, 17, 80), 64);
        for (int k = 81; k <= 96; k++) pat[k-81] = eh[k];
        want = 16'hF0F0;
        chk_int("k0_release_pat", int'(pat), int'(want));
        chk_int("k0_tail", count(0, 97, 100), 0);
        chk_int("k0_done_at", first_done(100), 97);
        A = 0;

        // key 11 (row D, col G): G follows D, other rows ignored
        strobe(11, 0);
        for (int i = 0; i < 20; i++) begin
            D = i[0];
            {C, B, A} = i[0] ? 3'b000 : 3'b111;
            #1;
            chk("k11_mirror", G, D);
            step(1);
        end
        {D, C, B, A} = 4'b0000;
        w = 0;
        while (!kif.ready && w < 200) begin step(1); w++; end
        chk("k11_back_idle", kif.ready, 1'b1);
        step(2);

        // Invalid code, then a press with strobes arriving while busy
        B = 1;
        kif.key_valid = 1'b1; kif.key_code = 4'd12; kif.key_bounce = 4'd0;
        step(1);
        chk("err_pulse", kif.err, 1'b1);
        chk("err_no_busy", kif.busy, 1'b0);
        strobe(3, 1);
        watch(90, 10);
        chk_int("busy_no_err", count(4, 1, 90), 0);
        chk_int("k3_e_high", count(0, 1, 90), 72);
        chk_int("k3_f_zero", count(1, 1, 90), 0);
        chk_int("k3_done_at", first_done(90), 81);
        B = 0;

        // Reset in the middle of HOLD
        A = 1;
        strobe(1, 0);
        step(20);
        chk("pre_rst_F", F, 1'b1);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("rst_async_F", F, 1'b0);
        chk("rst_async_busy", kif.busy, 1'b0);
        chk("rst_async_ready", kif.ready, 1'b1);
        step(2);
        #2 sys_rst_n = 1'b1;
        step(1);
        watch(80, 0);
        chk_int("rst_no_done", count(3, 1, 80), 0);
        chk_int("rst_f_zero", count(1, 1, 80), 0);
        strobe(1, 0);
        chk("post_rst_busy", kif.busy, 1'b1);
        chk("post_rst_F", F, 1'b1);
        w = 0;
        while (!kif.done && w < 200) begin step(1); w++; end
        chk("post_rst_done", kif.done, 1'b1);
        A = 0;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
